// File: rtl/wave_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_generator_if
// Brief    : Sample bus carrying the 12-bit unsigned waveform sample from
//            the generator (master) to its consumer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface wave_generator_if;
  logic [11:0] wave;

  modport master (output wave);
  modport slave  (input  wave);
endinterface
`default_nettype wire

// File: rtl/wave_generator.sv
`default_nettype none
// ============================================================================
// Module   : wave_generator
// Brief    : Free-running DDS-style waveform source. A 16-bit phase
//            accumulator advances by PHASE_STEP each clock and its pre-update
//            value is mapped to a sawtooth, triangle, square or sine sample.
// Revision : 1.0 - initial release
// ============================================================================
module wave_generator #(
  parameter logic [1:0]  WAVE_TYPE  = 2'd0,    // 0=saw 1=triangle 2=square 3=sine
  parameter logic [15:0] PHASE_STEP = 16'd64,  // accumulator increment per clock
  parameter int unsigned DUTY       = 2048     // square high while acc[15:4] < DUTY
) (
  input  logic             clk,
  input  logic             rst_n,
  wave_generator_if.master bus
);

  // Quarter-wave sine table packed 12 bits per entry, entry k at [12k +: 12].
  // L[k] = round(2047.5 + 2047.5*sin(pi*(2k+1)/1024)); the half-step offset
  // keeps the table symmetric so the four quadrants mirror exactly.
  function automatic logic [256*12-1:0] build_sine_rom();
    logic [256*12-1:0] rom;
    real               theta;
    real               x2;
    real               term;
    real               sum;
    int                val;
    rom = '0;
    for (int k = 0; k < 256; k++) begin
      theta = 3.141592653589793 * real'(2 * k + 1) / 1024.0;
      x2    = theta * theta;
      term  = theta;
      sum   = theta;
      // Taylor series; theta < pi/2 so 12 terms is far below one LSB.
      for (int n = 1; n <= 12; n++) begin
        term = -term * x2 / real'((2 * n) * (2 * n + 1));
        sum  = sum + term;
      end
      val = $rtoi(2047.5 + 2047.5 * sum + 0.5);
      if (val > 4095) val = 4095;
      if (val < 0)    val = 0;
      rom[k*12 +: 12] = val[11:0];
    end
    return rom;
  endfunction

  localparam logic [256*12-1:0] SINE_ROM = build_sine_rom();
  localparam logic [12:0]       DUTY_C   = 13'(DUTY);

  logic [15:0] acc;
  logic [11:0] wave_q;
  logic [11:0] saw_val;
  logic [11:0] tri_val;
  logic [11:0] sq_val;
  logic [7:0]  sine_idx;
  logic [11:0] sine_lut;
  logic [11:0] sine_val;
  logic [11:0] shape;

  // Sawtooth is the top 12 phase bits; triangle folds the upper half down so
  // the peak of 4095 lands just after the half-period point.
  assign saw_val = acc[15:4];
  assign tri_val = acc[15] ? ~acc[14:3] : acc[14:3];
  assign sq_val  = ({1'b0, acc[15:4]} < DUTY_C) ? 12'hFFF : 12'h000;

  // Odd quadrants read the table backwards (255-i == ~i); the lower half of
  // the period is the upper half inverted (4095-x == ~x).
  assign sine_idx = acc[14] ? ~acc[13:6] : acc[13:6];
  assign sine_lut = SINE_ROM[12*32'(sine_idx) +: 12];
  assign sine_val = acc[15] ? ~sine_lut : sine_lut;

  // Select the compile-time shape; the unused paths fold away as constants.
  always_comb begin
    shape = saw_val;
    case (WAVE_TYPE)
      2'd0:    shape = saw_val;
      2'd1:    shape = tri_val;
      2'd2:    shape = sq_val;
      default: shape = sine_val;
    endcase
  end

  // Advance the phase and register the sample of the pre-update phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 16'h0000;
      wave_q <= 12'h000;
    end else begin
      acc    <= acc + PHASE_STEP;
      wave_q <= shape;
    end
  end

  assign bus.wave = wave_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_generator
// Brief    : Directed self-checking bench for wave_generator; one instance per
//            shape/parameter set, all sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_generator;

  localparam int HIST = 1600;
  localparam int NVEC = 27;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  wave_generator_if if_saw ();
  wave_generator_if if_tri ();
  wave_generator_if if_sq50 ();
  wave_generator_if if_sq25 ();
  wave_generator_if if_sine ();
  wave_generator_if if_wrap ();

  wave_generator #(.WAVE_TYPE(2'd0), .PHASE_STEP(16'd64), .DUTY(2048))
    u_saw  (.clk(clk), .rst_n(rst_n), .bus(if_saw));
  wave_generator #(.WAVE_TYPE(2'd1), .PHASE_STEP(16'd64), .DUTY(2048))
    u_tri  (.clk(clk), .rst_n(rst_n), .bus(if_tri));
  wave_generator #(.WAVE_TYPE(2'd2), .PHASE_STEP(16'd64), .DUTY(2048))
    u_sq50 (.clk(clk), .rst_n(rst_n), .bus(if_sq50));
  wave_generator #(.WAVE_TYPE(2'd2), .PHASE_STEP(16'd64), .DUTY(1024))
    u_sq25 (.clk(clk), .rst_n(rst_n), .bus(if_sq25));
  wave_generator #(.WAVE_TYPE(2'd3), .PHASE_STEP(16'd64), .DUTY(2048))
    u_sine (.clk(clk), .rst_n(rst_n), .bus(if_sine));
  wave_generator #(.WAVE_TYPE(2'd0), .PHASE_STEP(16'hFFFF), .DUTY(2048))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_wrap));

  logic [11:0] w [6];
  assign w[0] = if_saw.wave;
  assign w[1] = if_tri.wave;
  assign w[2] = if_sq50.wave;
  assign w[3] = if_sq25.wave;
  assign w[4] = if_sine.wave;
  assign w[5] = if_wrap.wave;

  logic [11:0] hist [6][HIST];

  typedef struct {
    int          dut;
    int          cycle;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [NVEC];

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_known(input string name, input logic [11:0] act);
    n_cmp++;
    if ($isunknown(act)) begin
      n_bad++;
      $display("FAIL %s: got %h expected no X/Z", name, act);
    end
  endtask

  initial begin
    int m;
    n_cmp = 0;
    n_bad = 0;

    // Cycle n is the n-th rising edge after reset release (cycle 1 -> f(0)).
    vecs[0]  = '{0, 1,    12'd0,    "saw_c1"};
    vecs[1]  = '{0, 2,    12'd4,    "saw_c2"};
    vecs[2]  = '{0, 1024, 12'd4092, "saw_c1024"};
    vecs[3]  = '{0, 1025, 12'd0,    "saw_c1025"};
    vecs[4]  = '{1, 1,    12'd0,    "tri_c1"};
    vecs[5]  = '{1, 2,    12'd8,    "tri_c2"};
    vecs[6]  = '{1, 512,  12'd4088, "tri_c512"};
    vecs[7]  = '{1, 513,  12'd4095, "tri_c513"};
    vecs[8]  = '{1, 514,  12'd4087, "tri_c514"};
    vecs[9]  = '{1, 1024, 12'd7,    "tri_c1024"};
    vecs[10] = '{1, 1025, 12'd0,    "tri_c1025"};
    vecs[11] = '{2, 1,    12'd4095, "sq50_c1"};
    vecs[12] = '{2, 512,  12'd4095, "sq50_c512"};
    vecs[13] = '{2, 513,  12'd0,    "sq50_c513"};
    vecs[14] = '{2, 1024, 12'd0,    "sq50_c1024"};
    vecs[15] = '{2, 1025, 12'd4095, "sq50_c1025"};
    vecs[16] = '{3, 256,  12'd4095, "sq25_c256"};
    vecs[17] = '{3, 257,  12'd0,    "sq25_c257"};
    vecs[18] = '{3, 1024, 12'd0,    "sq25_c1024"};
    vecs[19] = '{4, 1,    12'd2054, "sine_c1"};
    vecs[20] = '{4, 256,  12'd4095, "sine_c256"};
    vecs[21] = '{4, 257,  12'd4095, "sine_c257"};
    vecs[22] = '{4, 513,  12'd2041, "sine_c513"};
    vecs[23] = '{4, 768,  12'd0,    "sine_c768"};
    vecs[24] = '{4, 769,  12'd0,    "sine_c769"};
    vecs[25] = '{5, 2,    12'd4095, "wrap_c2"};
    vecs[26] = '{5, 3,    12'd4095, "wrap_c3"};

    // Assert reset with a real falling edge and hold it for 3 clocks.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 6; d++) check($sformatf("reset_dut%0d", d), {1'b0, w[d]}, 13'd0);
    end

    // Release between edges and record the run.
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 10000; c++) begin
      @(posedge clk);
      #1;
      if (c < HIST) for (int d = 0; d < 6; d++) hist[d][c] = w[d];
      check_known($sformatf("wrap_known_c%0d", c), w[5]);
    end
    check("wrap_c1", {1'b0, hist[5][1]}, 13'd0);

    // Table of hand-computed points.
    for (int v = 0; v < NVEC; v++)
      check(vecs[v].name, {1'b0, hist[vecs[v].dut][vecs[v].cycle]}, {1'b0, vecs[v].exp});

    // Full-period sweeps of the piecewise-linear shapes.
    for (int c = 1; c <= 1100; c++) begin
      m = (c - 1) % 1024;
      check($sformatf("saw_c%0d", c),  {1'b0, hist[0][c]}, 13'(4 * m));
      check($sformatf("tri_c%0d", c),  {1'b0, hist[1][c]},
            (m < 512) ? 13'(8 * m) : 13'(4095 - 8 * (m - 512)));
      check($sformatf("sq50_c%0d", c), {1'b0, hist[2][c]}, (m < 512) ? 13'd4095 : 13'd0);
      check($sformatf("sq25_c%0d", c), {1'b0, hist[3][c]}, (m < 256) ? 13'd4095 : 13'd0);
    end

    // Sine half-period antisymmetry and full-period repeat.
    for (int c = 1; c <= 512; c++) begin
      check($sformatf("sine_sym_c%0d", c), {1'b0, hist[4][c]} + {1'b0, hist[4][c+512]}, 13'd4095);
      check($sformatf("sine_per_c%0d", c), {1'b0, hist[4][c+1024]}, {1'b0, hist[4][c]});
    end

    // Mid-run asynchronous reset: outputs clear before the next clock edge.
    check("saw_c10000", {1'b0, w[0]}, 13'd3132);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 6; d++) check($sformatf("async_rst_dut%0d", d), {1'b0, w[d]}, 13'd0);
    repeat (2) @(posedge clk);
    #1 check("hold_rst_saw", {1'b0, w[0]}, 13'd0);

    // After re-release the phase restarts from zero.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerun_saw_c1",  {1'b0, w[0]}, 13'd0);
    check("rerun_sine_c1", {1'b0, w[4]}, 13'd2054);
    @(posedge clk);
    #1;
    check("rerun_saw_c2",  {1'b0, w[0]}, 13'd4);
    check("rerun_tri_c2",  {1'b0, w[1]}, 13'd8);
    check("rerun_wrap_c2", {1'b0, w[5]}, 13'd4095);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
